uart_rx_buffer: RTL and testbench



---
 rtl/uart_pkg.sv | 31 +++
 rtl/uart_rx_buffer_if.sv | 39 +++
 rtl/uart_fifo_mem.sv | 28 ++
 rtl/uart_rx_buffer.sv | 119 +++++++++++
 tb/tb_uart_rx_buffer.sv | 302 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared UART receive-path definitions: word layout of a buffered frame and
// the error-counter ceiling.
package uart_pkg;

    localparam int UART_DATA_W = 8;
    localparam int RX_WORD_W   = 10;
    localparam int RXW_FERR    = 9;
    localparam int RXW_PERR    = 8;

    localparam logic [7:0] ERR_CNT_MAX = 8'd255;

    typedef struct packed {
        logic                   ferror;
        logic                   perror;
        logic [UART_DATA_W-1:0] data;
    } rx_word_t;

    function automatic logic [RX_WORD_W-1:0] pack_rx_word(
        input logic [UART_DATA_W-1:0] data,
        input logic                   ferror,
        input logic                   perror
    );
        logic [RX_WORD_W-1:0] w;
        w                        = '0;
        w[UART_DATA_W-1:0]       = data;
        w[RXW_FERR]              = ferror;
        w[RXW_PERR]              = perror;
        return w;
    endfunction

endpackage

// File: rtl/uart_rx_buffer_if.sv
// Receiver-side and consumer-side signals of the UART receive buffer.
// slave is the buffer's own view; master is the surrounding logic's view.
interface uart_rx_buffer_if #(
    parameter int DEPTH = 8
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic             Rx_EN;
    logic [7:0]       Rx_DATA;
    logic             Rx_FERROR;
    logic             Rx_PERROR;
    logic             Rx_VALID;

    logic             Buf_READY;
    logic [7:0]       Buf_DATA;
    logic             Buf_FERROR;
    logic             Buf_PERROR;
    logic             Buf_VALID;
    logic [CNT_W-1:0] Buf_COUNT;
    logic             Buf_FULL;
    logic             Buf_EMPTY;

    logic             Ovf_CLR;
    logic             Buf_OVERFLOW;
    logic [7:0]       Err_CNT;

    modport master (
        output Rx_EN, Rx_DATA, Rx_FERROR, Rx_PERROR, Rx_VALID, Buf_READY, Ovf_CLR,
        input  Buf_DATA, Buf_FERROR, Buf_PERROR, Buf_VALID, Buf_COUNT,
               Buf_FULL, Buf_EMPTY, Buf_OVERFLOW, Err_CNT
    );

    modport slave (
        input  Rx_EN, Rx_DATA, Rx_FERROR, Rx_PERROR, Rx_VALID, Buf_READY, Ovf_CLR,
        output Buf_DATA, Buf_FERROR, Buf_PERROR, Buf_VALID, Buf_COUNT,
               Buf_FULL, Buf_EMPTY, Buf_OVERFLOW, Err_CNT
    );

endinterface

// File: rtl/uart_fifo_mem.sv
// DEPTH x WIDTH register array: one synchronous write port, one asynchronous
// read port so the FIFO head is visible in the same cycle the pointer moves.
module uart_fifo_mem
    import uart_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int WIDTH = RX_WORD_W
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [WIDTH-1:0]         wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [WIDTH-1:0]         rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    // NOTE: the array has no reset; the owner's count says which slots are live.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/uart_rx_buffer.sv
// Captures each new frame from the UART receiver into a circular FIFO and
// presents it first-word-fall-through, with overflow and dropped-error status.
module uart_rx_buffer
    import uart_pkg::*;
#(
    parameter int DEPTH       = 8,
    parameter bit DROP_ERRORS = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    uart_rx_buffer_if.slave  bus
);

    localparam int               AW       = $clog2(DEPTH);
    localparam int               CNT_W    = AW + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic                 vld_q;
    logic [AW-1:0]        wr_ptr;
    logic [AW-1:0]        rd_ptr;
    logic [CNT_W-1:0]     count;
    logic [CNT_W-1:0]     count_next;
    logic                 overflow;
    logic [7:0]           err_cnt;

    logic                 new_frame;
    logic                 frame_bad;
    logic                 push_req;
    logic                 push_acc;
    logic                 pop;
    logic                 full;
    logic                 empty;
    logic                 ovf_set;
    logic                 err_inc;
    logic [RX_WORD_W-1:0] wr_word;
    logic [RX_WORD_W-1:0] rd_word;
    rx_word_t             head;

    // NOTE: every signal driven here gets a default first, so no latch can form.
    always_comb begin
        new_frame = bus.Rx_VALID & ~vld_q & bus.Rx_EN;
        frame_bad = DROP_ERRORS & (bus.Rx_FERROR | bus.Rx_PERROR);
        push_req  = new_frame & ~frame_bad;
        full      = (count == FULL_CNT);
        empty     = (count == '0);
        pop       = ~empty & bus.Buf_READY;
        push_acc  = push_req & (~full | pop);
        ovf_set   = push_req & full & ~pop;
        err_inc   = new_frame & frame_bad & (err_cnt != ERR_CNT_MAX);

        count_next = count;
        unique case ({push_acc, pop})
            2'b10:   count_next = count + 1'b1;
            2'b01:   count_next = count - 1'b1;
            default: count_next = count;
        endcase
    end

    assign wr_word = pack_rx_word(bus.Rx_DATA, bus.Rx_FERROR, bus.Rx_PERROR);

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            // vld_q comes up high so a level already asserted at release is not a new frame.
            vld_q    <= 1'b1;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
            err_cnt  <= '0;
        end else begin
            vld_q <= bus.Rx_VALID;
            count <= count_next;
            if (push_acc) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            // A fresh overflow in the same cycle as a clear must stay visible.
            if (ovf_set) begin
                overflow <= 1'b1;
            end else if (bus.Ovf_CLR) begin
                overflow <= 1'b0;
            end
            if (err_inc) begin
                err_cnt <= err_cnt + 8'd1;
            end
        end
    end

    uart_fifo_mem #(
        .DEPTH (DEPTH),
        .WIDTH (RX_WORD_W)
    ) u_mem (
        .clk   (clk),
        .we    (push_acc),
        .waddr (wr_ptr),
        .wdata (wr_word),
        .raddr (rd_ptr),
        .rdata (rd_word)
    );

    assign head = rx_word_t'(rd_word);

    assign bus.Buf_DATA     = head.data;
    assign bus.Buf_FERROR   = head.ferror;
    assign bus.Buf_PERROR   = head.perror;
    assign bus.Buf_VALID    = ~empty;
    assign bus.Buf_COUNT    = count;
    assign bus.Buf_FULL     = full;
    assign bus.Buf_EMPTY    = empty;
    assign bus.Buf_OVERFLOW = overflow;
    assign bus.Err_CNT      = err_cnt;

    a_count_range : assert property (@(posedge clk) disable iff (reset) count <= FULL_CNT);
    a_no_pop_empty : assert property (@(posedge clk) disable iff (reset) !(pop && empty));

endmodule

// File: tb/tb_uart_rx_buffer.sv
// Self-checking bench: two buffers (errors kept / errors dropped) driven by the
// same stimulus and compared each cycle against a queue-based reference model.
module tb_uart_rx_buffer;

    localparam int DEPTH = 8;

    logic       clk = 1'b0;
    logic       reset;
    logic       rx_en;
    logic [7:0] rx_data;
    logic       rx_ferr;
    logic       rx_perr;
    logic       rx_valid;
    logic       buf_ready;
    logic       ovf_clr;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    uart_rx_buffer_if #(.DEPTH(DEPTH)) if_keep ();
    uart_rx_buffer_if #(.DEPTH(DEPTH)) if_drop ();

    assign if_keep.Rx_EN     = rx_en;
    assign if_keep.Rx_DATA   = rx_data;
    assign if_keep.Rx_FERROR = rx_ferr;
    assign if_keep.Rx_PERROR = rx_perr;
    assign if_keep.Rx_VALID  = rx_valid;
    assign if_keep.Buf_READY = buf_ready;
    assign if_keep.Ovf_CLR   = ovf_clr;

    assign if_drop.Rx_EN     = rx_en;
    assign if_drop.Rx_DATA   = rx_data;
    assign if_drop.Rx_FERROR = rx_ferr;
    assign if_drop.Rx_PERROR = rx_perr;
    assign if_drop.Rx_VALID  = rx_valid;
    assign if_drop.Buf_READY = buf_ready;
    assign if_drop.Ovf_CLR   = ovf_clr;

    uart_rx_buffer #(.DEPTH(DEPTH), .DROP_ERRORS(1'b0)) u_keep (
        .clk   (clk),
        .reset (reset),
        .bus   (if_keep.slave)
    );

    uart_rx_buffer #(.DEPTH(DEPTH), .DROP_ERRORS(1'b1)) u_drop (
        .clk   (clk),
        .reset (reset),
        .bus   (if_drop.slave)
    );

    // Reference model: stored frames as plain queues of {ferr, perr, data}.
    logic [9:0] q_keep[$];
    logic [9:0] q_drop[$];
    bit         m_prev  = 1'b1;
    bit         m_ovf_k = 1'b0;
    bit         m_ovf_d = 1'b0;
    int         m_err   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        logic [9:0] w;
        bit         nf;
        bit         bad;
        w   = {rx_ferr, rx_perr, rx_data};
        nf  = rx_valid && !m_prev && rx_en;
        bad = rx_ferr || rx_perr;
        if (reset) begin
            q_keep.delete();
            q_drop.delete();
            m_ovf_k = 1'b0;
            m_ovf_d = 1'b0;
            m_err   = 0;
            m_prev  = 1'b1;
        end else begin
            if (buf_ready && q_keep.size() != 0) void'(q_keep.pop_front());
            if (buf_ready && q_drop.size() != 0) void'(q_drop.pop_front());
            if (ovf_clr) begin
                m_ovf_k = 1'b0;
                m_ovf_d = 1'b0;
            end
            if (nf) begin
                if (q_keep.size() < DEPTH) q_keep.push_back(w);
                else m_ovf_k = 1'b1;
                if (bad) begin
                    if (m_err < 255) m_err++;
                end else if (q_drop.size() < DEPTH) begin
                    q_drop.push_back(w);
                end else begin
                    m_ovf_d = 1'b1;
                end
            end
            m_prev = rx_valid;
        end
    endtask

    task automatic compare_all();
        check("keep_count", 32'(if_keep.Buf_COUNT), q_keep.size());
        check("keep_valid", 32'(if_keep.Buf_VALID), 32'(q_keep.size() != 0));
        check("keep_empty", 32'(if_keep.Buf_EMPTY), 32'(q_keep.size() == 0));
        check("keep_full", 32'(if_keep.Buf_FULL), 32'(q_keep.size() == DEPTH));
        check("keep_ovf", 32'(if_keep.Buf_OVERFLOW), 32'(m_ovf_k));
        check("keep_errcnt", 32'(if_keep.Err_CNT), 0);
        if (q_keep.size() != 0)
            check("keep_head", {22'd0, if_keep.Buf_FERROR, if_keep.Buf_PERROR, if_keep.Buf_DATA},
                  32'(q_keep[0]));
        check("drop_count", 32'(if_drop.Buf_COUNT), q_drop.size());
        check("drop_valid", 32'(if_drop.Buf_VALID), 32'(q_drop.size() != 0));
        check("drop_empty", 32'(if_drop.Buf_EMPTY), 32'(q_drop.size() == 0));
        check("drop_full", 32'(if_drop.Buf_FULL), 32'(q_drop.size() == DEPTH));
        check("drop_ovf", 32'(if_drop.Buf_OVERFLOW), 32'(m_ovf_d));
        check("drop_errcnt", 32'(if_drop.Err_CNT), m_err);
        if (q_drop.size() != 0)
            check("drop_head", {22'd0, if_drop.Buf_FERROR, if_drop.Buf_PERROR, if_drop.Buf_DATA},
                  32'(q_drop[0]));
    endtask

    // One clock: inputs already set, model advances with the DUT edge, outputs compared mid-cycle.
    task automatic cycle();
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare_all();
    endtask

    task automatic push_frame(input logic [7:0] d, input logic f, input logic p);
        rx_data  = d;
        rx_ferr  = f;
        rx_perr  = p;
        rx_valid = 1'b1;
        cycle();
        rx_valid = 1'b0;
        cycle();
    endtask

    typedef struct {
        logic       rst, en, vld, ferr, perr, rdy, clr;
        logic [7:0] data;
        int         keep_cnt, drop_cnt, err;
        logic [9:0] keep_head, drop_head;
    } vec_t;

    vec_t vecs[18];

    initial begin
        logic [9:0] hd;

        reset     = 1'b1;
        rx_en     = 1'b1;
        rx_data   = 8'h00;
        rx_ferr   = 1'b0;
        rx_perr   = 1'b0;
        rx_valid  = 1'b0;
        buf_ready = 1'b0;
        ovf_clr   = 1'b0;

        //            rst en vld fe pe rdy clr data   kc dc er  khead    dhead
        vecs[0]  = '{1, 1, 0, 0, 0, 0, 0, 8'h00, 0, 0, 0, 10'h000, 10'h000};
        vecs[1]  = '{0, 1, 0, 0, 0, 0, 0, 8'h00, 0, 0, 0, 10'h000, 10'h000};
        vecs[2]  = '{0, 1, 1, 0, 0, 0, 0, 8'h41, 1, 1, 0, 10'h041, 10'h041};
        vecs[3]  = '{0, 1, 0, 0, 0, 0, 0, 8'h41, 1, 1, 0, 10'h041, 10'h041};
        vecs[4]  = '{0, 1, 0, 0, 0, 1, 0, 8'h41, 0, 0, 0, 10'h000, 10'h000};
        vecs[5]  = '{0, 1, 1, 0, 1, 0, 0, 8'h10, 1, 0, 1, 10'h110, 10'h000};
        vecs[6]  = '{0, 1, 0, 0, 0, 0, 0, 8'h10, 1, 0, 1, 10'h110, 10'h000};
        vecs[7]  = '{0, 1, 1, 0, 0, 0, 0, 8'h11, 2, 1, 1, 10'h110, 10'h011};
        vecs[8]  = '{0, 1, 1, 0, 0, 0, 0, 8'h11, 2, 1, 1, 10'h110, 10'h011};
        vecs[9]  = '{0, 1, 0, 0, 0, 0, 0, 8'h11, 2, 1, 1, 10'h110, 10'h011};
        vecs[10] = '{0, 0, 1, 0, 0, 0, 0, 8'h33, 2, 1, 1, 10'h110, 10'h011};
        vecs[11] = '{0, 1, 0, 0, 0, 0, 0, 8'h33, 2, 1, 1, 10'h110, 10'h011};
        vecs[12] = '{1, 1, 1, 0, 0, 0, 0, 8'h44, 0, 0, 0, 10'h000, 10'h000};
        vecs[13] = '{0, 1, 1, 0, 0, 0, 0, 8'h44, 0, 0, 0, 10'h000, 10'h000};
        vecs[14] = '{0, 1, 1, 0, 0, 0, 0, 8'h44, 0, 0, 0, 10'h000, 10'h000};
        vecs[15] = '{0, 1, 0, 0, 0, 0, 0, 8'h44, 0, 0, 0, 10'h000, 10'h000};
        vecs[16] = '{0, 1, 1, 0, 0, 0, 0, 8'h22, 1, 1, 0, 10'h022, 10'h022};
        vecs[17] = '{0, 1, 0, 0, 0, 1, 0, 8'h22, 0, 0, 0, 10'h000, 10'h000};

        @(negedge clk);
        for (int i = 0; i < 18; i++) begin
            reset     = vecs[i].rst;
            rx_en     = vecs[i].en;
            rx_valid  = vecs[i].vld;
            rx_ferr   = vecs[i].ferr;
            rx_perr   = vecs[i].perr;
            buf_ready = vecs[i].rdy;
            ovf_clr   = vecs[i].clr;
            rx_data   = vecs[i].data;
            cycle();
            check($sformatf("vec%0d_keep_count", i), 32'(if_keep.Buf_COUNT), vecs[i].keep_cnt);
            check($sformatf("vec%0d_drop_count", i), 32'(if_drop.Buf_COUNT), vecs[i].drop_cnt);
            check($sformatf("vec%0d_errcnt", i), 32'(if_drop.Err_CNT), vecs[i].err);
            if (vecs[i].keep_cnt != 0)
                check($sformatf("vec%0d_keep_head", i),
                      {22'd0, if_keep.Buf_FERROR, if_keep.Buf_PERROR, if_keep.Buf_DATA},
                      32'(vecs[i].keep_head));
            if (vecs[i].drop_cnt != 0)
                check($sformatf("vec%0d_drop_head", i),
                      {22'd0, if_drop.Buf_FERROR, if_drop.Buf_PERROR, if_drop.Buf_DATA},
                      32'(vecs[i].drop_head));
        end
        reset     = 1'b0;
        rx_en     = 1'b1;
        buf_ready = 1'b0;
        ovf_clr   = 1'b0;
        rx_valid  = 1'b0;
        rx_ferr   = 1'b0;
        rx_perr   = 1'b0;
        cycle();

        // Level held high for 20 cycles yields exactly one entry.
        rx_data  = 8'h5A;
        rx_valid = 1'b1;
        repeat (20) cycle();
        rx_valid = 1'b0;
        cycle();
        check("hold_high_count", 32'(if_keep.Buf_COUNT), 1);
        buf_ready = 1'b1;
        cycle();
        buf_ready = 1'b0;
        check("hold_high_drained", 32'(if_keep.Buf_EMPTY), 1);

        // Fill, overflow, set-wins-over-clear, clear, then ordered drain.
        for (int i = 0; i < DEPTH; i++) push_frame(8'(i), 1'b0, 1'b0);
        check("fill_full", 32'(if_keep.Buf_FULL), 1);
        check("fill_no_ovf", 32'(if_keep.Buf_OVERFLOW), 0);
        push_frame(8'hFF, 1'b0, 1'b0);
        check("ovf_set", 32'(if_keep.Buf_OVERFLOW), 1);
        check("ovf_count", 32'(if_keep.Buf_COUNT), DEPTH);
        rx_data  = 8'hEE;
        rx_valid = 1'b1;
        ovf_clr  = 1'b1;
        cycle();
        check("ovf_set_wins", 32'(if_keep.Buf_OVERFLOW), 1);
        rx_valid = 1'b0;
        ovf_clr  = 1'b0;
        cycle();
        ovf_clr = 1'b1;
        cycle();
        ovf_clr = 1'b0;
        check("ovf_cleared", 32'(if_keep.Buf_OVERFLOW), 0);
        buf_ready = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            check($sformatf("drain_order%0d", i), 32'(if_keep.Buf_DATA), i);
            cycle();
        end
        buf_ready = 1'b0;
        check("drain_empty", 32'(if_keep.Buf_EMPTY), 1);

        // Full buffer accepting a push in the same cycle as a pop.
        for (int i = 0; i < DEPTH; i++) push_frame(8'h81 + 8'(i), 1'b0, 1'b0);
        rx_data   = 8'h55;
        rx_valid  = 1'b1;
        buf_ready = 1'b1;
        cycle();
        rx_valid = 1'b0;
        check("fullpop_count", 32'(if_keep.Buf_COUNT), DEPTH);
        check("fullpop_no_ovf", 32'(if_keep.Buf_OVERFLOW), 0);
        for (int i = 0; i < DEPTH; i++) begin
            hd = (i == DEPTH - 1) ? 10'h055 : 10'(8'h82 + 8'(i));
            check($sformatf("fullpop_drain%0d", i), 32'(if_keep.Buf_DATA), 32'(hd));
            cycle();
        end
        buf_ready = 1'b0;
        check("fullpop_empty", 32'(if_keep.Buf_EMPTY), 1);

        // Error counter saturates at 255.
        buf_ready = 1'b1;
        for (int i = 0; i < 260; i++) push_frame(8'(i), 1'b1, 1'b0);
        check("err_saturate", 32'(if_drop.Err_CNT), 255);
        check("err_not_stored", 32'(if_drop.Buf_EMPTY), 1);
        buf_ready = 1'b0;

        reset = 1'b1;
        cycle();
        reset = 1'b0;
        cycle();

        // Randomised traffic: a draining phase then a congested phase.
        for (int i = 0; i < 600; i++) begin
            rx_valid  = 1'($urandom_range(0, 1));
            rx_data   = 8'($urandom);
            rx_ferr   = ($urandom_range(0, 7) == 0);
            rx_perr   = ($urandom_range(0, 7) == 0);
            rx_en     = ($urandom_range(0, 9) != 0);
            ovf_clr   = ($urandom_range(0, 15) == 0);
            buf_ready = (i < 300) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
            reset     = ($urandom_range(0, 199) == 0);
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
